mem_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the 64 KB memory block and the processor core.
- Accepts a byte stream (valid/ready) carrying a small header and a program image, and writes the image into memory.
- Optionally writes the 6502 reset vector, then releases the processor from reset.
- Replaces hand-placing instructions in the memory array before simulation and bring-up.

---
 rtl/mem_loader.sv | 133 +++++++++++++
 tb/tb_mem_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Boot loader: parses a little-endian header plus image from a byte
// stream, writes it to memory, optionally the reset vector, then releases the core.
module mem_loader #(
  parameter bit          WRITE_VECTOR = 1'b1,
  parameter logic [15:0] VECTOR_ADDR  = 16'hFFFC,
  parameter int unsigned RESET_HOLD   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_enable,
  output logic        mem_wr_enable,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wr_data,
  output logic        proc_resetn,
  output logic        done
);

  localparam int HW =
    (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RESET_HOLD - 1);

  typedef enum logic [3:0] {
    HDR_ADDR_LO,
    HDR_ADDR_HI,
    HDR_LEN_LO,
    HDR_LEN_HI,
    DATA,
    VEC_LO,
    VEC_HI,
    HOLD,
    RUN
  } state_t;

  state_t        state;
  logic [15:0]   load_addr;
  logic [7:0]    len_lo;
  logic [15:0]   remaining;
  logic [15:0]   wr_ptr;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic [15:0]   hdr_len;
  state_t        post_data;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      in_ready = state inside {
        HDR_ADDR_LO, HDR_ADDR_HI,
        HDR_LEN_LO, HDR_LEN_HI, DATA};
    end
  end

  assign mem_enable = !reset;
  assign accept     = in_valid && in_ready;
  assign hdr_len    = {in_data, len_lo};
  assign post_data  = WRITE_VECTOR ? VEC_LO : HOLD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HDR_ADDR_LO;
      load_addr     <= '0;
      len_lo        <= '0;
      remaining     <= '0;
      wr_ptr        <= '0;
      hold_cnt      <= '0;
      mem_wr_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
      proc_resetn   <= 1'b0;
      done          <= 1'b0;
    end else begin
      mem_wr_enable <= 1'b0;
      case (state)
        HDR_ADDR_LO: if (accept) begin
          load_addr[7:0] <= in_data;
          state          <= HDR_ADDR_HI;
        end
        HDR_ADDR_HI: if (accept) begin
          load_addr[15:8] <= in_data;
          state           <= HDR_LEN_LO;
        end
        HDR_LEN_LO: if (accept) begin
          len_lo <= in_data;
          state  <= HDR_LEN_HI;
        end
        HDR_LEN_HI: if (accept) begin
          remaining <= hdr_len;
          wr_ptr    <= load_addr;
          state     <= (hdr_len != 16'd0)
                       ? DATA : post_data;
        end
        DATA: if (accept) begin
          mem_wr_enable <= 1'b1;
          mem_addr      <= wr_ptr;
          mem_wr_data   <= in_data;
          wr_ptr        <= wr_ptr + 16'd1;
          remaining     <= remaining - 16'd1;
          if (remaining == 16'd1)
            state <= post_data;
        end
        VEC_LO: begin
          mem_wr_enable <= 1'b1;
          mem_addr      <= VECTOR_ADDR;
          mem_wr_data   <= load_addr[7:0];
          state         <= VEC_HI;
        end
        VEC_HI: begin
          mem_wr_enable <= 1'b1;
          mem_addr      <= VECTOR_ADDR + 16'd1;
          mem_wr_data   <= load_addr[15:8];
          state         <= HOLD;
        end
        HOLD: begin
          // core stays in reset while the last write settles
          if (hold_cnt == HOLD_LAST) begin
            state       <= RUN;
            proc_resetn <= 1'b1;
            done        <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: ;
        default: state <= HDR_ADDR_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table of
// load streams plus reset and post-done sequences.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  always #5 clk = ~clk;

  logic        rdy0, en0, we0, pr0, dn0;
  logic        rdy1, en1, we1, pr1, dn1;
  logic [15:0] a0, a1;
  logic [7:0]  d0, d1;

  mem_loader dut0 (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .mem_enable(en0),
    .mem_wr_enable(we0), .mem_addr(a0),
    .mem_wr_data(d0), .proc_resetn(pr0),
    .done(dn0)
  );

  mem_loader #(.WRITE_VECTOR(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .mem_enable(en1),
    .mem_wr_enable(we1), .mem_addr(a1),
    .mem_wr_data(d1), .proc_resetn(pr1),
    .done(dn1)
  );

  int sel = 0;
  logic        rdy, en, we, pr, dn;
  logic [15:0] a;
  logic [7:0]  d;

  assign rdy = (sel == 0) ? rdy0 : rdy1;
  assign en  = (sel == 0) ? en0  : en1;
  assign we  = (sel == 0) ? we0  : we1;
  assign pr  = (sel == 0) ? pr0  : pr1;
  assign dn  = (sel == 0) ? dn0  : dn1;
  assign a   = (sel == 0) ? a0   : a1;
  assign d   = (sel == 0) ? d0   : d1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] qa[$];
  logic [7:0]  qd[$];
  int          qc[$];
  int          done_cyc = -1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      qa.push_back(a);
      qd.push_back(d);
      qc.push_back(cyc);
    end
    if (dn === 1'b1 && done_cyc < 0)
      done_cyc = cyc;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic clear_log();
    qa.delete();
    qd.delete();
    qc.delete();
    done_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rdy;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dn === 1'b1) break;
    end
    chk(nm, 32'(dn), 1);
  endtask

  typedef struct {
    string            name;
    int               n_in;
    logic [0:7][7:0]  bytes;
    int               gap;
    int               sel;
    int               n_wr;
    logic [0:5][15:0] wa;
    logic [0:5][7:0]  wd;
  } vec_t;

  vec_t tv[6];

  initial begin
    tv[0] = '{"basic", 7,
      {8'h00, 8'h02, 8'h03, 8'h00,
       8'hA9, 8'h01, 8'hEA, 8'h00},
      0, 0, 5,
      {16'h0200, 16'h0201, 16'h0202,
       16'hFFFC, 16'hFFFD, 16'h0000},
      {8'hA9, 8'h01, 8'hEA,
       8'h00, 8'h02, 8'h00}};
    tv[1] = '{"gaps", 7,
      {8'h00, 8'h02, 8'h03, 8'h00,
       8'hA9, 8'h01, 8'hEA, 8'h00},
      3, 0, 5,
      {16'h0200, 16'h0201, 16'h0202,
       16'hFFFC, 16'hFFFD, 16'h0000},
      {8'hA9, 8'h01, 8'hEA,
       8'h00, 8'h02, 8'h00}};
    tv[2] = '{"wrap", 8,
      {8'hFE, 8'hFF, 8'h04, 8'h00,
       8'h11, 8'h22, 8'h33, 8'h44},
      0, 0, 6,
      {16'hFFFE, 16'hFFFF, 16'h0000,
       16'h0001, 16'hFFFC, 16'hFFFD},
      {8'h11, 8'h22, 8'h33,
       8'h44, 8'hFE, 8'hFF}};
    tv[3] = '{"zero_len", 4,
      {8'h00, 8'h80, 8'h00, 8'h00,
       8'h00, 8'h00, 8'h00, 8'h00},
      0, 0, 2,
      {16'hFFFC, 16'hFFFD, 16'h0000,
       16'h0000, 16'h0000, 16'h0000},
      {8'h00, 8'h80, 8'h00,
       8'h00, 8'h00, 8'h00}};
    tv[4] = '{"no_vector", 7,
      {8'h00, 8'h02, 8'h03, 8'h00,
       8'hA9, 8'h01, 8'hEA, 8'h00},
      0, 1, 3,
      {16'h0200, 16'h0201, 16'h0202,
       16'h0000, 16'h0000, 16'h0000},
      {8'hA9, 8'h01, 8'hEA,
       8'h00, 8'h00, 8'h00}};
    tv[5] = '{"overlap", 6,
      {8'hFC, 8'hFF, 8'h02, 8'h00,
       8'hAA, 8'hBB, 8'h00, 8'h00},
      0, 0, 4,
      {16'hFFFC, 16'hFFFD, 16'hFFFC,
       16'hFFFD, 16'h0000, 16'h0000},
      {8'hAA, 8'hBB, 8'hFC,
       8'hFF, 8'h00, 8'h00}};

    // reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(rdy), 0);
    chk("rst_mem_enable", 32'(en), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_wr_en", 32'(we), 0);
    chk("rst_addr", 32'(a), 0);
    chk("rst_data", 32'(d), 0);
    chk("rst_proc_resetn", 32'(pr), 0);
    chk("rst_done", 32'(dn), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int t = 0; t < 6; t++) begin
      int n;
      sel = tv[t].sel;
      do_reset();
      clear_log();
      for (int i = 0; i < tv[t].n_in; i++) begin
        send_byte(tv[t].bytes[i]);
        if (i >= 4 && i < tv[t].n_in - 1
            && tv[t].gap > 0) begin
          repeat (tv[t].gap) @(posedge clk);
          #1;
        end
      end
      wait_done({tv[t].name, "_done"});
      repeat (2) @(negedge clk);
      n = qa.size();
      chk({tv[t].name, "_nwr"}, 32'(n),
          32'(tv[t].n_wr));
      for (int i = 0; i < n && i < tv[t].n_wr;
           i++) begin
        chk({tv[t].name, "_addr"}, 32'(qa[i]),
            32'(tv[t].wa[i]));
        chk({tv[t].name, "_data"}, 32'(qd[i]),
            32'(tv[t].wd[i]));
      end
      if (n > 0 && done_cyc >= 0)
        chk({tv[t].name, "_hold"},
            32'(done_cyc - qc[n-1]), 4);
      if (tv[t].gap == 0 && n > 1)
        chk({tv[t].name, "_b2b"},
            32'(qc[n-1] - qc[0]), 32'(n - 1));
      chk({tv[t].name, "_rdy_off"},
          32'(rdy), 0);
      chk({tv[t].name, "_resetn"}, 32'(pr), 1);
    end

    // reset in the middle of the data phase
    sel = 0;
    do_reset();
    clear_log();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'hA9);
    send_byte(8'h01);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rdy", 32'(rdy), 0);
    chk("mid_en", 32'(en), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_wr_en", 32'(we), 0);
    chk("mid_addr", 32'(a), 0);
    chk("mid_data", 32'(d), 0);
    chk("mid_resetn", 32'(pr), 0);
    chk("mid_done", 32'(dn), 0);
    chk("mid_rdy_back", 32'(rdy), 1);
    @(posedge clk);
    #1;
    clear_log();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h60);
    wait_done("mid_done2");
    repeat (2) @(negedge clk);
    chk("mid_nwr", 32'(qa.size()), 3);
    if (qa.size() == 3) begin
      chk("mid_a0", 32'(qa[0]), 32'h0300);
      chk("mid_d0", 32'(qd[0]), 32'h60);
      chk("mid_a1", 32'(qa[1]), 32'hFFFC);
      chk("mid_d1", 32'(qd[1]), 32'h00);
      chk("mid_a2", 32'(qa[2]), 32'hFFFD);
      chk("mid_d2", 32'(qd[2]), 32'h03);
    end

    // bytes offered after done are refused
    begin
      int n0;
      n0 = qa.size();
      #1;
      in_data  = 8'h55;
      in_valid = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("post_rdy", 32'(rdy), 0);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_nwr", 32'(qa.size()), 32'(n0));
      chk("post_done", 32'(dn), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
